// File: rtl/digital_tube_scan_counter_if.sv
// Button/display bundle for digital_tube_scan_counter: increment/clear in, segments/selects/value out.
interface digital_tube_scan_counter_if #(
  parameter int NUM_DIGITS = 2
);
  logic [NUM_DIGITS-1:0]   add;
  logic                    clr;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   sel;
  logic [4*NUM_DIGITS-1:0] value;

  modport master (output add, clr, input seg, sel, value);
  modport slave  (input add, clr, output seg, sel, value);
endinterface

// File: rtl/digital_tube_scan_counter.sv
// Per-digit BCD/hex counters driving a multiplexed 7-segment display with a blank gap.
// Define TUBE_CARRY_EN to chain the digits into one ripple-carry counter.
module digital_tube_scan_counter #(
  parameter int NUM_DIGITS     = 2,
  parameter int BASE           = 10,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_DIGITS-1:0]   i_add,
  input  logic                    i_clr,
  output logic [6:0]              o_digitalTube,
  output logic [NUM_DIGITS-1:0]   o_sel,
  output logic [4*NUM_DIGITS-1:0] o_value
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [PW-1:0]              pre_q, pre_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [NUM_DIGITS-1:0]      sel_q, sel_d;
  logic [6:0]                 seg_q, seg_d;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'h3F;  4'h1: enc = 7'h06;  4'h2: enc = 7'h5B;  4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66;  4'h5: enc = 7'h6D;  4'h6: enc = 7'h7D;  4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F;  4'h9: enc = 7'h6F;  4'hA: enc = 7'h77;  4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39;  4'hD: enc = 7'h5E;  4'hE: enc = 7'h79;  default: enc = 7'h71;
    endcase
  endfunction

  always_comb begin
    logic [4:0] sum;
`ifdef TUBE_CARRY_EN
    logic cy;
    cy = 1'b0;
`endif
    digit_d = digit_q;
    sum     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef TUBE_CARRY_EN
      sum = {1'b0, digit_q[k]} + 5'(i_add[k]) + 5'(cy);
      cy  = (sum >= 5'(BASE));
`else
      sum = {1'b0, digit_q[k]} + 5'(i_add[k]);
`endif
      // sum never reaches 2*BASE, so one subtraction is the full modulo
      digit_d[k] = (sum >= 5'(BASE)) ? 4'(sum - 5'(BASE)) : sum[3:0];
    end
    if (i_clr) digit_d = '0;
  end

  always_comb begin
    pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_MAX) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    if (32'(pre_q) >= BLANK_CYCLES) begin
      sel_d = (NUM_DIGITS'(1) << idx_q) ^ SEL_OFF;
      seg_d = enc(digit_q[idx_q]) ^ SEG_OFF;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      digit_q <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      digit_q <= digit_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign o_value       = digit_q;
  assign o_sel         = sel_q;
  assign o_digitalTube = seg_q;
endmodule

// File: tb/tb_digital_tube_scan_counter.sv
// Scoreboard bench for digital_tube_scan_counter: directed plan scenarios plus random pulses.
module tb_digital_tube_scan_counter;
  localparam int N = 2, BASE = 10, SCAN_DIV = 4, BLANK = 1;

  typedef struct packed {
    logic [4*N-1:0] value;
    logic [N-1:0]   sel;
    logic [6:0]     seg;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  digital_tube_scan_counter_if #(.NUM_DIGITS(N)) bus ();

  digital_tube_scan_counter #(
    .NUM_DIGITS(N), .BASE(BASE), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_add(bus.add), .i_clr(bus.clr),
    .o_digitalTube(bus.seg), .o_sel(bus.sel), .o_value(bus.value)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  exp_t q[$];
  int   dig[N];
  int   cyc;
  logic [6:0] enc_tbl[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*N-1:0] pack_model();
    logic [4*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[4*k +: 4] = 4'(dig[k]);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) dig[k] = 0;
    cyc = 0;
  endtask

  // Drive one cycle's inputs at the falling edge and queue what the next rising edge must produce.
  task automatic step(input logic [N-1:0] add, input logic clr);
    exp_t e;
    int pre, idx, total, span;
    @(negedge clk);
    bus.add = add;
    bus.clr = clr;
    pre = cyc % SCAN_DIV;
    idx = (cyc / SCAN_DIV) % N;
    e.sel = '0;
    e.seg = '0;
    if (pre >= BLANK) begin
      e.sel = N'(1 << idx);
      e.seg = enc_tbl[dig[idx]];
    end
    if (clr) begin
      for (int k = 0; k < N; k++) dig[k] = 0;
    end else begin
`ifdef TUBE_CARRY_EN
      total = 0; span = 1;
      for (int k = 0; k < N; k++) begin
        total += (dig[k] + int'(add[k])) * span;
        span  *= BASE;
      end
      total %= span;
      for (int k = 0; k < N; k++) begin
        dig[k] = total % BASE;
        total /= BASE;
      end
`else
      total = 0; span = 0;
      for (int k = 0; k < N; k++) dig[k] = (dig[k] + int'(add[k])) % BASE;
`endif
    end
    e.value = pack_model();
    q.push_back(e);
    cyc++;
  endtask

  task automatic pulses(input int n, input logic [N-1:0] add);
    for (int i = 0; i < n; i++) step(add, 1'b0);
  endtask

  task automatic after_edge_value(input string name, input logic [31:0] exp);
    @(posedge clk); #2;
    chk(name, 32'(bus.value), exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_value", 32'(bus.value), 32'(e.value));
        chk("sb_sel",   32'(bus.sel),   32'(e.sel));
        chk("sb_seg",   32'(bus.seg),   32'(e.seg));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [N-1:0] sel_seq[8];
    sel_seq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
    bus.add = '0;
    bus.clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_value", 32'(bus.value), 32'h00);
    chk("rst_sel",   32'(bus.sel),   32'h0);
    chk("rst_seg",   32'(bus.seg),   32'h00);
    rst_n = 1'b1;

    // scan order from reset, first lit slot shows digit 0 = '0'
    for (int i = 0; i < 8; i++) begin
      step('0, 1'b0);
      @(posedge clk); #2;
      chk("scan_sel", 32'(bus.sel), 32'(sel_seq[i]));
      if (i == 1) chk("first_lit_seg", 32'(bus.seg), 32'h3F);
    end

    pulses(3, 2'b01);
    step(2'b10, 1'b0);
    after_edge_value("incr_13", 32'h13);
    pulses(8, 2'b00);

    step('0, 1'b1);
    pulses(9, 2'b01);
    after_edge_value("nine", 32'h09);
    step(2'b01, 1'b0);
`ifdef TUBE_CARRY_EN
    after_edge_value("wrap_carry", 32'h10);
`else
    after_edge_value("wrap_nocarry", 32'h00);
`endif

    step('0, 1'b1);
    pulses(9, 2'b10);
    pulses(9, 2'b01);
    after_edge_value("ninety_nine", 32'h99);
    step(2'b01, 1'b0);
`ifdef TUBE_CARRY_EN
    after_edge_value("99_plus_1", 32'h00);
`else
    after_edge_value("99_plus_1", 32'h90);
`endif

    step('0, 1'b1);
    pulses(9, 2'b01);
    step(2'b11, 1'b0);
`ifdef TUBE_CARRY_EN
    after_edge_value("09_plus_11", 32'h20);
`else
    after_edge_value("09_plus_11", 32'h10);
`endif
    step(2'b11, 1'b1);
    after_edge_value("clr_priority", 32'h00);

    // held-high pulses count every cycle
    pulses(5, 2'b10);
    pulses(7, 2'b01);
    after_edge_value("value_57", 32'h57);
    #1;
    bus.add = '0;
    rst_n = 1'b0;
    #1;
    chk("async_value", 32'(bus.value), 32'h00);
    chk("async_sel",   32'(bus.sel),   32'h0);
    chk("async_seg",   32'(bus.seg),   32'h00);
    repeat (2) @(posedge clk);
    #2;
    model_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++)
      step(N'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
    step('0, 1'b0);
    @(posedge clk); #2;
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
